div_exe: RTL and testbench

Iterative radix-2 integer divider implementing the RV32M DIV/DIVU/REM/REMU ops. It sits on the DIV execution pipe (EXE_PIPE_ID_DIV) as the responder to the IX stage. It consumes `ix_div_inf_t` requests and returns `div_wb_inf_t` results to the WB arbiter. DIV holds the lowest WB priority, so the block holds each finished result until WB accepts it.

---
 rtl/div_exe.sv | 178 +++++++++++++++++
 tb/tb_div_exe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_exe.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Accepts one op from IX, resolves divide-by-zero and signed overflow at
// accept time, otherwise iterates 32 edges, then holds the result for WB.

package defines;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  // bit1 selects remainder, bit0 selects unsigned operands
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    div_op_e               div_control;
  } ix_div_inf_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] result;
  } div_wb_inf_t;
endpackage

module div_exe
  import defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ix_div_valid,
  input  ix_div_inf_t ix_div_inf,
  output logic        div_ready,
  output logic        div_wb_valid,
  output div_wb_inf_t div_wb_inf,
  input  logic        wb_div_ready,
  input  logic        flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_reg, state_next;
  logic [4:0]            count_reg;
  logic [DATA_WIDTH-1:0] rem_reg;
  logic [DATA_WIDTH-1:0] quot_reg;     // dividend shifts out, quotient shifts in
  logic [DATA_WIDTH-1:0] divisor_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic [REG_WIDTH-1:0]  rd_reg;
  logic                  is_rem_reg;
  logic                  neg_q_reg;
  logic                  neg_r_reg;

  logic                  accept;
  logic                  is_rem_in;
  logic                  sign1, sign2;
  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic                  special;
  logic [DATA_WIDTH-1:0] special_result;

  logic [DATA_WIDTH:0]   part;
  logic                  take;
  logic [DATA_WIDTH-1:0] rem_new;
  logic [DATA_WIDTH-1:0] quot_new;
  logic [DATA_WIDTH-1:0] final_result;

  // Operand decode at accept: signs, magnitudes and the two special cases
  always_comb begin
    is_rem_in      = ix_div_inf.div_control[1];
    sign1          = !ix_div_inf.div_control[0] && ix_div_inf.rs1[DATA_WIDTH-1];
    sign2          = !ix_div_inf.div_control[0] && ix_div_inf.rs2[DATA_WIDTH-1];
    mag1           = sign1 ? (~ix_div_inf.rs1 + 32'd1) : ix_div_inf.rs1;
    mag2           = sign2 ? (~ix_div_inf.rs2 + 32'd1) : ix_div_inf.rs2;
    special        = 1'b0;
    special_result = '0;
    if (ix_div_inf.rs2 == 32'd0) begin
      special        = 1'b1;
      special_result = is_rem_in ? ix_div_inf.rs1 : 32'hFFFF_FFFF;
    end else if (!ix_div_inf.div_control[0] &&
                 ix_div_inf.rs1 == 32'h8000_0000 &&
                 ix_div_inf.rs2 == 32'hFFFF_FFFF) begin
      special        = 1'b1;
      special_result = is_rem_in ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step plus sign correction for the final iteration
  always_comb begin
    part     = {rem_reg, quot_reg[DATA_WIDTH-1]};
    take     = (part >= {1'b0, divisor_reg});
    // when take is set the difference is below 2^32, so 32-bit subtract is exact
    rem_new  = take ? (part[DATA_WIDTH-1:0] - divisor_reg) : part[DATA_WIDTH-1:0];
    quot_new = {quot_reg[DATA_WIDTH-2:0], take};
    if (is_rem_reg)
      final_result = neg_r_reg ? (~rem_new + 32'd1) : rem_new;
    else
      final_result = neg_q_reg ? (~quot_new + 32'd1) : quot_new;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic; flush overrides accept and the WB handshake
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ix_div_valid && !flush) begin
          accept     = 1'b1;
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (count_reg == 5'd0)
          state_next = DONE;
      end
      DONE: begin
        if (wb_div_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  // Datapath: latch operands on accept, iterate in CALC, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      divisor_reg <= '0;
      result_reg  <= '0;
      rd_reg      <= '0;
      is_rem_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
    end else if (accept) begin
      rd_reg      <= ix_div_inf.rd;
      is_rem_reg  <= is_rem_in;
      neg_q_reg   <= sign1 ^ sign2;
      neg_r_reg   <= sign1;
      count_reg   <= 5'd31;
      rem_reg     <= '0;
      quot_reg    <= mag1;
      divisor_reg <= mag2;
      if (special)
        result_reg <= special_result;
    end else if (state_reg == CALC && !flush) begin
      rem_reg  <= rem_new;
      quot_reg <= quot_new;
      if (count_reg == 5'd0)
        result_reg <= final_result;
      else
        count_reg <= count_reg - 5'd1;
    end
  end

  assign div_ready         = (state_reg == IDLE);
  assign div_wb_valid      = (state_reg == DONE);
  assign div_wb_inf.rd     = rd_reg;
  assign div_wb_inf.result = result_reg;

endmodule

// File: tb/tb_div_exe.sv
// Self-checking bench for div_exe: vector table plus randomized ops against
// a behavioural model, scoreboard queue, and hand-written corner sequences.

module tb_div_exe;
  import defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ix_div_valid;
  ix_div_inf_t ix_div_inf;
  logic        div_ready;
  logic        div_wb_valid;
  div_wb_inf_t div_wb_inf;
  logic        wb_div_ready;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    div_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] result;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  div_exe dut (
    .clk          (clk),
    .rst          (rst),
    .ix_div_valid (ix_div_valid),
    .ix_div_inf   (ix_div_inf),
    .div_ready    (div_ready),
    .div_wb_valid (div_wb_valid),
    .div_wb_inf   (div_wb_inf),
    .wb_div_ready (wb_div_ready),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0)
      return (op == DIV_OP_DIV || op == DIV_OP_DIVU) ? 32'hFFFF_FFFF : a;
    if ((op == DIV_OP_DIV || op == DIV_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == DIV_OP_DIV) ? 32'h8000_0000 : 32'd0;
    case (op)
      DIV_OP_DIV:  return sa / sb;
      DIV_OP_REM:  return sa % sb;
      DIV_OP_DIVU: return a / b;
      default:     return a % b;
    endcase
  endfunction

  function automatic int model_lat(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if ((op == DIV_OP_DIV || op == DIV_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic vec_t mk(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Called at a negedge: present the request, wait for the accept edge
  task automatic issue(input vec_t v);
    exp_t e;
    int   g;
    g = 0;
    while (!div_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!div_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout div_ready stuck low");
    end
    ix_div_valid           = 1'b1;
    ix_div_inf.rd          = v.rd;
    ix_div_inf.rs1         = v.a;
    ix_div_inf.rs2         = v.b;
    ix_div_inf.div_control = v.op;
    e.rd = v.rd; e.result = v.exp; e.lat = v.lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1 ix_div_valid = 1'b0;
  endtask

  // Wait for valid after the accept edge, compare latency and payload
  task automatic wait_result(input string name);
    exp_t e;
    int   lat;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      lat = i;
      if (div_wb_valid) break;
    end
    if (!div_wb_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout no div_wb_valid within 100 cycles", name);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard result with empty queue", name);
      return;
    end
    e = sb_q.pop_front();
    chk({name, "_lat"}, lat, e.lat);
    chk({name, "_rd"}, {27'd0, div_wb_inf.rd}, {27'd0, e.rd});
    chk({name, "_result"}, div_wb_inf.result, e.result);
    $display("txn %s rd=%0d result=%08h latency=%0d", name, div_wb_inf.rd, div_wb_inf.result, lat);
  endtask

  // Handshake at the next edge, then check div_ready in the following cycle
  task automatic handshake(input string name);
    wb_div_ready = 1'b1;
    @(posedge clk);
    #1 wb_div_ready = 1'b0;
    @(negedge clk);
    chk({name, "_ready_after_hs"}, {31'd0, div_ready}, 32'd1);
    chk({name, "_valid_after_hs"}, {31'd0, div_wb_valid}, 32'd0);
  endtask

  task automatic run(input vec_t v, input string name);
    issue(v);
    wait_result(name);
    handshake(name);
  endtask

  initial begin
    vec_t        v;
    logic        seen;
    logic [31:0] ra, rb;
    div_op_e     rop;

    rst          = 1'b1;
    ix_div_valid = 1'b0;
    ix_div_inf   = '0;
    wb_div_ready = 1'b0;
    flush        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, div_ready}, 32'd1);
    chk("reset_valid", {31'd0, div_wb_valid}, 32'd0);
    chk("reset_inf", {div_wb_inf.rd, div_wb_inf.result[26:0]}, 32'd0);
    chk("reset_inf_hi", {27'd0, div_wb_inf.result[31:27]}, 32'd0);

    // Directed table from the reference cases
    vecs.push_back(mk(DIV_OP_DIV,  32'd100,      32'd7,        5'd1,  32'd14,        33));
    vecs.push_back(mk(DIV_OP_REM,  32'd100,      32'd7,        5'd2,  32'd2,         33));
    vecs.push_back(mk(DIV_OP_REM,  32'hFFFFFF9C, 32'd7,        5'd3,  32'hFFFFFFFE,  33));
    vecs.push_back(mk(DIV_OP_DIV,  32'hFFFFFF9C, 32'd7,        5'd4,  32'hFFFFFFF2,  33));
    vecs.push_back(mk(DIV_OP_DIVU, 32'hFFFFFF9C, 32'd7,        5'd5,  32'h24924916,  33));
    vecs.push_back(mk(DIV_OP_DIVU, 32'hFFFFFFFF, 32'd0,        5'd6,  32'hFFFFFFFF,  1));
    vecs.push_back(mk(DIV_OP_REMU, 32'h1234,     32'd0,        5'd7,  32'h1234,      1));
    vecs.push_back(mk(DIV_OP_DIV,  32'd5,        32'd0,        5'd8,  32'hFFFFFFFF,  1));
    vecs.push_back(mk(DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000,  1));
    vecs.push_back(mk(DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd10, 32'd0,         1));
    vecs.push_back(mk(DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,         33));
    vecs.push_back(mk(DIV_OP_REM,  32'd7,        32'hFFFFFFFD, 5'd0,  32'd1,         33));
    vecs.push_back(mk(DIV_OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 5'd31, 32'd3,         33));
    vecs.push_back(mk(DIV_OP_REMU, 32'hFFFFFFFF, 32'h10,       5'd12, 32'hF,         33));

    // Randomized ops against the behavioural model
    for (int i = 0; i < 8; i++) begin
      rop = div_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 3) rb = 32'hFFFFFFFF;
      vecs.push_back(mk(rop, ra, rb, 5'(i + 13), model(rop, ra, rb), model_lat(rop, ra, rb)));
    end

    for (int i = 0; i < vecs.size(); i++)
      run(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold WB off for 10 cycles, outputs must not move
    issue(mk(DIV_OP_DIV, 32'd1000, 32'd33, 5'd17, 32'd30, 33));
    wait_result("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (!div_wb_valid || div_ready || div_wb_inf.rd !== 5'd17 || div_wb_inf.result !== 32'd30) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%0b ready=%0b rd=%0d result=%08h want valid=1 ready=0 rd=17 result=0000001e",
                 i, div_wb_valid, div_ready, div_wb_inf.rd, div_wb_inf.result);
      end
    end
    $display("txn bp_hold held 10 cycles");
    // Request presented alongside the handshake must not be accepted then
    ix_div_valid           = 1'b1;
    ix_div_inf.rd          = 5'd18;
    ix_div_inf.rs1         = 32'd144;
    ix_div_inf.rs2         = 32'd12;
    ix_div_inf.div_control = DIV_OP_DIVU;
    wb_div_ready           = 1'b1;
    @(posedge clk);
    #1 wb_div_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_hs", {31'd0, div_ready}, 32'd1);
    issue(mk(DIV_OP_DIVU, 32'd144, 32'd12, 5'd18, 32'd12, 33));
    wait_result("bp_next");
    handshake("bp_next");

    // Flush at CALC iteration 10
    issue(mk(DIV_OP_DIV, 32'd123456, 32'd7, 5'd19, 32'd17636, 33));
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", {31'd0, div_ready}, 32'd1);
    void'(sb_q.pop_front());
    seen = div_wb_valid;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | div_wb_valid;
    end
    chk("flush_no_valid", {31'd0, seen}, 32'd0);
    $display("txn flush aborted op rd=19");
    run(mk(DIV_OP_DIV, 32'd81, 32'd9, 5'd20, 32'd9, 33), "after_flush");

    // Reset at CALC iteration 10
    issue(mk(DIV_OP_REM, 32'd123456, 32'd7, 5'd21, 32'd4, 33));
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    void'(sb_q.pop_front());
    chk("rst_ready", {31'd0, div_ready}, 32'd1);
    chk("rst_valid", {31'd0, div_wb_valid}, 32'd0);
    chk("rst_inf_result", div_wb_inf.result, 32'd0);
    chk("rst_inf_rd", {27'd0, div_wb_inf.rd}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | div_wb_valid;
    end
    chk("rst_no_valid", {31'd0, seen}, 32'd0);
    $display("txn reset aborted op rd=21");
    run(mk(DIV_OP_DIV, 32'd81, 32'd9, 5'd22, 32'd9, 33), "after_rst");

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
